ex_issue_ctrl: RTL and testbench

//  Issue controller for the EX-stage ALU. Accepts decoded ops from ID via a valid/ready handshake.

---
 rtl/ex_issue_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ex_issue_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_issue_ctrl.sv
// ex_issue_ctrl - issue controller for the EX-stage ALU.
//
// Takes decoded ops from ID over a valid/ready handshake. A 32-entry register
// scoreboard interlocks RAW hazards. The controller counts out the ALU or MUL
// latency and then presents the result to EX/MEM over a valid/ready handshake.
// At most one op is in flight at a time.
//
// Parameters
//   MUL_CYCLES  issue-to-result cycles for opcode 5 (MUL), legal 2..15
//   ALU_CYCLES  issue-to-result cycles for every other opcode, legal 1..15
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   id_valid / id_ready       ID handshake
//   id_opcode, id_src_a, id_src_b, id_uses_b, id_dest
//                             decoded op fields from ID
//   alu_start, alu_opcode     one-cycle operand-sample strobe, and the opcode
//                             held for the ALU
//   ex_valid / ex_ready       EX/MEM result handshake
//   ex_dest, ex_illegal       destination and undefined-opcode flag of the
//                             presented result
//   wb_valid, wb_dest         writeback retire, which clears a scoreboard bit
//   busy                      controller not idle
//
// Optional build macro
//   EX_PERF_CNT_EN  adds the stall_cnt[31:0] and op_cnt[31:0] performance
//                   counters
//
// State table
//   IDLE | no op in flight; accepts an op when there is no hazard
//   EXEC | op issued; cnt counts down the remaining latency
//   DONE | result presented on ex_*; waiting for ex_ready

module ex_issue_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int ALU_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [5:0]  id_opcode,
    input  logic [4:0]  id_src_a,
    input  logic [4:0]  id_src_b,
    input  logic        id_uses_b,
    input  logic [4:0]  id_dest,
    output logic        alu_start,
    output logic [5:0]  alu_opcode,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [4:0]  ex_dest,
    output logic        ex_illegal,
    input  logic        wb_valid,
    input  logic [4:0]  wb_dest,
    output logic        busy
`ifdef EX_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] op_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] OP_MUL   = 6'd5;
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] ALU_LOAD = 4'(ALU_CYCLES - 1);

    state_t      state;
    logic [31:0] sb;
    logic [31:0] sb_set;
    logic [31:0] sb_clr;
    logic [31:0] sb_next;
    logic [3:0]  cnt;
    logic        pend_illegal;
    logic        hazard;
    logic        transfer;
    logic        opcode_legal;

    // The hazard check reads only registered state. A retire therefore
    // unblocks ID one cycle after the wb edge, because there is no bypass.
    assign hazard   = sb[id_src_a] | (id_uses_b & sb[id_src_b]);
    assign id_ready = (state == IDLE) & ~hazard;
    assign transfer = id_valid & id_ready;
    assign busy     = (state != IDLE);

    always_comb begin
        opcode_legal = 1'b0;
        case (id_opcode)
            6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5,
            6'd8, 6'd9, 6'd10, 6'd11, 6'd12: opcode_legal = 1'b1;
            default:                         opcode_legal = 1'b0;
        endcase
    end

    // Set is ORed in after the clear, so a set on the same edge wins.
    // Register 0 never holds a pending write.
    always_comb begin
        sb_set = '0;
        sb_clr = '0;
        if (transfer && (id_dest != 5'd0))
            sb_set[id_dest] = 1'b1;
        if (wb_valid && (wb_dest != 5'd0))
            sb_clr[wb_dest] = 1'b1;
        sb_next = ((sb & ~sb_clr) | sb_set) & ~32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            sb           <= '0;
            cnt          <= '0;
            pend_illegal <= 1'b0;
            alu_start    <= 1'b0;
            alu_opcode   <= '0;
            ex_valid     <= 1'b0;
            ex_dest      <= '0;
            ex_illegal   <= 1'b0;
        end else begin
            sb        <= sb_next;
            alu_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (transfer) begin
                        alu_start    <= 1'b1;
                        alu_opcode   <= id_opcode;
                        ex_dest      <= id_dest;
                        pend_illegal <= ~opcode_legal;
                        cnt          <= (id_opcode == OP_MUL) ? MUL_LOAD : ALU_LOAD;
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        ex_valid   <= 1'b1;
                        ex_illegal <= pend_illegal;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    // ex_valid is known high here, so ex_ready alone completes the handshake.
                    if (ex_ready) begin
                        ex_valid   <= 1'b0;
                        ex_illegal <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef EX_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            op_cnt    <= '0;
        end else begin
            if (id_valid && (state == IDLE) && hazard)
                stall_cnt <= stall_cnt + 32'd1;
            if (transfer)
                op_cnt <= op_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_issue_ctrl.sv
module tb_ex_issue_ctrl;

    localparam int MUL_LAT = 4;
    localparam int ALU_LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic        id_ready;
    logic [5:0]  id_opcode;
    logic [4:0]  id_src_a;
    logic [4:0]  id_src_b;
    logic        id_uses_b;
    logic [4:0]  id_dest;
    logic        alu_start;
    logic [5:0]  alu_opcode;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_dest;
    logic        ex_illegal;
    logic        wb_valid;
    logic [4:0]  wb_dest;
    logic        busy;
`ifdef EX_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] op_cnt;
`endif

    int total = 0;
    int bad   = 0;

    ex_issue_ctrl #(.MUL_CYCLES(MUL_LAT), .ALU_CYCLES(ALU_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_opcode  (id_opcode),
        .id_src_a   (id_src_a),
        .id_src_b   (id_src_b),
        .id_uses_b  (id_uses_b),
        .id_dest    (id_dest),
        .alu_start  (alu_start),
        .alu_opcode (alu_opcode),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_dest    (ex_dest),
        .ex_illegal (ex_illegal),
        .wb_valid   (wb_valid),
        .wb_dest    (wb_dest),
        .busy       (busy)
`ifdef EX_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .op_cnt     (op_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic [4:0] a;
        logic [4:0] b;
        logic       ub;
        logic [4:0] d;
        int         lat;
        logic       ill;
        int         hold;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one op, check the strobe and latency, hold the result for 'hold'
    // cycles, then accept it (optionally retiring the dest on the same edge).
    task automatic run_op(input logic [5:0] op, input logic [4:0] a, input logic [4:0] b,
                          input logic ub, input logic [4:0] d, input int exp_lat,
                          input logic exp_ill, input int hold, input logic do_wb);
        int n;
`ifdef EX_PERF_CNT_EN
        logic [31:0] ops_before;
`endif
        @(negedge clk);
        id_opcode = op; id_src_a = a; id_src_b = b; id_uses_b = ub; id_dest = d;
        id_valid = 1'b1;
        n = 0;
        while (!id_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!id_ready) begin
            chk("id_ready_timeout", 32'(id_ready), 32'd1);
            id_valid = 1'b0;
            return;
        end
`ifdef EX_PERF_CNT_EN
        ops_before = op_cnt;
`endif
        @(negedge clk);
        id_valid = 1'b0;
        chk("alu_start", 32'(alu_start), 32'd1);
        chk("alu_opcode", 32'(alu_opcode), 32'(op));
        chk("busy_exec", 32'(busy), 32'd1);
`ifdef EX_PERF_CNT_EN
        chk("op_cnt_inc", op_cnt - ops_before, 32'd1);
`endif
        n = 0;
        while (!ex_valid && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("alu_start_drop", 32'(alu_start), 32'd0);
        end
        chk("latency", 32'(n), 32'(exp_lat));
        chk("ex_dest", 32'(ex_dest), 32'(d));
        chk("ex_illegal", 32'(ex_illegal), 32'(exp_ill));
        chk("id_ready_done", 32'(id_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_ex_valid", 32'(ex_valid), 32'd1);
            chk("hold_ex_dest", 32'(ex_dest), 32'(d));
        end
        ex_ready = 1'b1;
        if (do_wb) begin
            wb_valid = 1'b1;
            wb_dest  = d;
        end
        @(negedge clk);
        ex_ready = 1'b0;
        wb_valid = 1'b0;
        chk("ex_valid_drop", 32'(ex_valid), 32'd0);
        chk("busy_drop", 32'(busy), 32'd0);
    endtask

    initial begin : main
        int n;
        logic [31:0] stall_before;
        stall_before = '0;

        vecs[0] = '{6'd0,  5'd1, 5'd2, 1'b1, 5'd3,  ALU_LAT, 1'b0, 0};
        vecs[1] = '{6'd5,  5'd1, 5'd2, 1'b1, 5'd4,  MUL_LAT, 1'b0, 0};
        vecs[2] = '{6'd7,  5'd3, 5'd4, 1'b0, 5'd6,  ALU_LAT, 1'b1, 0};
        vecs[3] = '{6'd12, 5'd5, 5'd6, 1'b1, 5'd31, ALU_LAT, 1'b0, 0};
        vecs[4] = '{6'd13, 5'd2, 5'd3, 1'b1, 5'd12, ALU_LAT, 1'b1, 0};
        vecs[5] = '{6'd6,  5'd2, 5'd3, 1'b1, 5'd13, ALU_LAT, 1'b1, 0};
        vecs[6] = '{6'd8,  5'd1, 5'd1, 1'b0, 5'd14, ALU_LAT, 1'b0, 0};
        vecs[7] = '{6'd63, 5'd0, 5'd0, 1'b1, 5'd15, ALU_LAT, 1'b1, 0};
        vecs[8] = '{6'd5,  5'd6, 5'd7, 1'b1, 5'd5,  MUL_LAT, 1'b0, 3};

        rst = 1'b1;
        id_valid = 1'b0; id_opcode = '0; id_src_a = '0; id_src_b = '0;
        id_uses_b = 1'b0; id_dest = '0; ex_ready = 1'b0; wb_valid = 1'b0; wb_dest = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_alu_start", 32'(alu_start), 32'd0);
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_id_ready", 32'(id_ready), 32'd1);

        for (int i = 0; i < 9; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ub, vecs[i].d,
                   vecs[i].lat, vecs[i].ill, vecs[i].hold, 1'b1);

        // Reset in the middle of a MUL
        @(negedge clk);
        id_opcode = 6'd5; id_src_a = 5'd1; id_src_b = 5'd2; id_uses_b = 1'b0; id_dest = 5'd10;
        id_valid = 1'b1;
        @(negedge clk);
        id_valid = 1'b0;
        chk("mulrst_issued", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mulrst_busy", 32'(busy), 32'd0);
        chk("mulrst_ex_valid", 32'(ex_valid), 32'd0);
        chk("mulrst_alu_start", 32'(alu_start), 32'd0);
        chk("mulrst_alu_opcode", 32'(alu_opcode), 32'd0);
        chk("mulrst_ex_dest", 32'(ex_dest), 32'd0);
        chk("mulrst_ex_illegal", 32'(ex_illegal), 32'd0);
        id_src_a = 5'd10;
        #1 chk("mulrst_id_ready", 32'(id_ready), 32'd1);
        run_op(6'd0, 5'd10, 5'd0, 1'b0, 5'd11, ALU_LAT, 1'b0, 0, 1'b1);

        // RAW interlock on src_b
        run_op(6'd1, 5'd1, 5'd2, 1'b1, 5'd7, ALU_LAT, 1'b0, 0, 1'b0);
        @(negedge clk);
        id_opcode = 6'd0; id_src_a = 5'd1; id_src_b = 5'd7; id_uses_b = 1'b1; id_dest = 5'd8;
`ifdef EX_PERF_CNT_EN
        stall_before = stall_cnt;
`endif
        id_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("raw_block", 32'(id_ready), 32'd0);
        end
        id_valid = 1'b0;
`ifdef EX_PERF_CNT_EN
        chk("stall_cnt", stall_cnt - stall_before, 32'd5);
`endif
        id_uses_b = 1'b0;
        #1 chk("raw_imm_not_blocked", 32'(id_ready), 32'd1);
        id_uses_b = 1'b1;
        #1 chk("raw_block_again", 32'(id_ready), 32'd0);
        wb_valid = 1'b1; wb_dest = 5'd7;
        #1 chk("raw_no_bypass", 32'(id_ready), 32'd0);
        @(negedge clk);
        wb_valid = 1'b0;
        chk("raw_release", 32'(id_ready), 32'd1);
        run_op(6'd0, 5'd1, 5'd7, 1'b1, 5'd8, ALU_LAT, 1'b0, 0, 1'b1);

        // Same-edge set and clear of register 9: the set wins
        @(negedge clk);
        id_opcode = 6'd2; id_src_a = 5'd1; id_src_b = 5'd2; id_uses_b = 1'b0; id_dest = 5'd9;
        id_valid = 1'b1; wb_valid = 1'b1; wb_dest = 5'd9;
        chk("same_edge_ready", 32'(id_ready), 32'd1);
        @(negedge clk);
        id_valid = 1'b0; wb_valid = 1'b0;
        chk("same_edge_alu_start", 32'(alu_start), 32'd1);
        n = 0;
        while (!ex_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("same_edge_latency", 32'(n), 32'(ALU_LAT));
        ex_ready = 1'b1;
        @(negedge clk);
        ex_ready = 1'b0;
        id_src_a = 5'd9; id_uses_b = 1'b0;
        #1 chk("same_edge_sb9_set", 32'(id_ready), 32'd0);
        wb_valid = 1'b1; wb_dest = 5'd9;
        @(negedge clk);
        wb_valid = 1'b0;
        chk("sb9_cleared", 32'(id_ready), 32'd1);

        // Register 0 never stalls
        run_op(6'd3, 5'd0, 5'd0, 1'b1, 5'd0, ALU_LAT, 1'b0, 0, 1'b0);
        id_src_a = 5'd0; id_src_b = 5'd0; id_uses_b = 1'b1;
        #1 chk("r0_no_stall", 32'(id_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
